uart_tx_scheduler: RTL and testbench

Shares the single UART transmitter between the two byte sources of the analyzer: the metadata/ID sender and the sample-FIFO readout path. It replaces the static transmit mux with a registered arbiter. Each burst is granted whole, one byte at a time, using a req/ack handshake. Every byte is paced by the UART `tx_busy` status. The block sits between the two sources and `UART_com`, and it is sequenced by the controller through `abort` and the status outputs.

---
 rtl/uart_tx_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Registered arbiter that shares one UART transmitter between the metadata
// sender and the sample-FIFO readout path. A granted source keeps the UART
// for its whole burst. Bytes are taken one at a time over a req/ack
// handshake and paced by the UART tx_busy status. BUSY_TIMEOUT must be at
// least 1.
module uart_tx_scheduler #(
    parameter int BUSY_TIMEOUT = 16,
    parameter int COUNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               m_req,
    input  logic [7:0]         m_byte,
    input  logic               m_last,
    output logic               m_ack,
    input  logic               s_req,
    input  logic [7:0]         s_byte,
    input  logic               s_last,
    output logic               s_ack,
    input  logic               abort,
    input  logic               tx_busy,
    output logic               trans_en,
    output logic [7:0]         tx_data,
    output logic [1:0]         grant,
    output logic               active,
    output logic [COUNT_W-1:0] byte_count
);

    localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_NEXT      = 3'd4;
    localparam logic [2:0] ST_DRAIN     = 3'd5;

    localparam logic [1:0] GNT_NONE   = 2'b00;
    localparam logic [1:0] GNT_META   = 2'b01;
    localparam logic [1:0] GNT_SAMPLE = 2'b10;

    logic [2:0]         r_state;
    logic               r_last;
    logic [TO_W-1:0]    r_to_cnt;
    logic               r_m_ack;
    logic               r_s_ack;
    logic               r_trans_en;
    logic [7:0]         r_tx_data;
    logic [1:0]         r_grant;
    logic               r_active;
    logic [COUNT_W-1:0] r_byte_count;

    // Byte counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        if (v == {COUNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + COUNT_W'(1'b1);
        end
    endfunction

    // Arbiter FSM; every output is a register updated here.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last       <= 1'b0;
            r_to_cnt     <= '0;
            r_m_ack      <= 1'b0;
            r_s_ack      <= 1'b0;
            r_trans_en   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_grant      <= GNT_NONE;
            r_active     <= 1'b0;
            r_byte_count <= '0;
        end else begin
            // Acks and the transmit strobe are single-cycle pulses.
            r_m_ack    <= 1'b0;
            r_s_ack    <= 1'b0;
            r_trans_en <= 1'b0;

            if (abort && (r_state != ST_IDLE)) begin
                // Flush beats any latch in the same cycle; a frame already on
                // the wire is allowed to finish in DRAIN.
                r_grant <= GNT_NONE;
                if (tx_busy) begin
                    r_state  <= ST_DRAIN;
                    r_active <= 1'b1;
                end else begin
                    r_state  <= ST_IDLE;
                    r_active <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // Fixed priority, decided only between bursts.
                        if (m_req) begin
                            r_grant      <= GNT_META;
                            r_m_ack      <= 1'b1;
                            r_tx_data    <= m_byte;
                            r_last       <= m_last;
                            r_byte_count <= COUNT_W'(1'b1);
                            r_state      <= ST_SEND;
                            r_active     <= 1'b1;
                        end else if (s_req) begin
                            r_grant      <= GNT_SAMPLE;
                            r_s_ack      <= 1'b1;
                            r_tx_data    <= s_byte;
                            r_last       <= s_last;
                            r_byte_count <= COUNT_W'(1'b1);
                            r_state      <= ST_SEND;
                            r_active     <= 1'b1;
                        end
                    end
                    ST_SEND: begin
                        r_trans_en <= 1'b1;
                        r_to_cnt   <= '0;
                        r_state    <= ST_WAIT_BUSY;
                    end
                    ST_WAIT_BUSY: begin
                        // A UART that never reports busy must not stall the
                        // burst: after the timeout fall through to WAIT_DONE,
                        // which exits at once while tx_busy stays low.
                        if (tx_busy || (r_to_cnt == TO_W'(BUSY_TIMEOUT))) begin
                            r_state <= ST_WAIT_DONE;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1'b1);
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (!tx_busy) begin
                            if (r_last) begin
                                r_state  <= ST_IDLE;
                                r_grant  <= GNT_NONE;
                                r_active <= 1'b0;
                            end else begin
                                r_state <= ST_NEXT;
                            end
                        end
                    end
                    ST_NEXT: begin
                        // Burst lock: only the granted source is served.
                        if ((r_grant == GNT_META) && m_req) begin
                            r_m_ack      <= 1'b1;
                            r_tx_data    <= m_byte;
                            r_last       <= m_last;
                            r_byte_count <= sat_inc(r_byte_count);
                            r_state      <= ST_SEND;
                        end else if ((r_grant == GNT_SAMPLE) && s_req) begin
                            r_s_ack      <= 1'b1;
                            r_tx_data    <= s_byte;
                            r_last       <= s_last;
                            r_byte_count <= sat_inc(r_byte_count);
                            r_state      <= ST_SEND;
                        end
                    end
                    ST_DRAIN: begin
                        if (!tx_busy) begin
                            r_state  <= ST_IDLE;
                            r_active <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_grant  <= GNT_NONE;
                        r_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign m_ack      = r_m_ack;
    assign s_ack      = r_s_ack;
    assign trans_en   = r_trans_en;
    assign tx_data    = r_tx_data;
    assign grant      = r_grant;
    assign active     = r_active;
    assign byte_count = r_byte_count;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler: reset, simultaneous
// requests, single burst pacing, burst lock, busy timeout and abort/drain.
module tb_uart_tx_scheduler;

    logic        clock;
    logic        reset_n;
    logic        m_req, s_req, m_last, s_last;
    logic [7:0]  m_byte, s_byte;
    logic        m_ack, s_ack;
    logic        abort;
    logic        tx_busy;
    logic        trans_en;
    logic [7:0]  tx_data;
    logic [1:0]  grant;
    logic        active;
    logic [15:0] byte_count;

    uart_tx_scheduler #(.BUSY_TIMEOUT(16), .COUNT_W(16)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .m_req      (m_req),
        .m_byte     (m_byte),
        .m_last     (m_last),
        .m_ack      (m_ack),
        .s_req      (s_req),
        .s_byte     (s_byte),
        .s_last     (s_last),
        .s_ack      (s_ack),
        .abort      (abort),
        .tx_busy    (tx_busy),
        .trans_en   (trans_en),
        .tx_data    (tx_data),
        .grant      (grant),
        .active     (active),
        .byte_count (byte_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source models: a burst is a small byte table walked on each ack.
    logic [7:0] m_mem [16];
    logic [7:0] s_mem [16];
    int m_len = 0, s_len = 0, m_idx = 0, s_idx = 0;
    logic m_en, s_en;

    assign m_req  = m_en && (m_idx < m_len);
    assign s_req  = s_en && (s_idx < s_len);
    assign m_byte = m_mem[m_idx[3:0]];
    assign s_byte = s_mem[s_idx[3:0]];
    assign m_last = (m_idx == m_len - 1);
    assign s_last = (s_idx == s_len - 1);

    // Advance a source to its next byte in the cycle after its ack.
    always @(posedge clock) begin
        if (!reset_n) begin
            m_idx <= 0;
            s_idx <= 0;
        end else begin
            if (m_ack) m_idx <= m_idx + 1;
            if (s_ack) s_idx <= s_idx + 1;
        end
    end

    // UART model: busy rises one cycle after the strobe, lasts 20 cycles.
    logic uart_on;
    logic u_busy = 1'b0;
    int   u_cnt  = 0;
    assign tx_busy = u_busy;

    always @(posedge clock) begin
        if (!uart_on) begin
            u_busy <= 1'b0;
            u_cnt  <= 0;
        end else if (trans_en) begin
            u_busy <= 1'b1;
            u_cnt  <= 19;
        end else if (u_cnt != 0) begin
            u_cnt <= u_cnt - 1;
        end else begin
            u_busy <= 1'b0;
        end
    end

    // Monitor: log strobes and flag acks that break the grant rules.
    logic [7:0] st_data [64];
    int         st_time [64];
    int         n_st = 0, cyc = 0, n_mack = 0;
    int         lock_viol = 0, grant_bad = 0;
    logic [1:0] prev_grant = 2'b00;

    always @(negedge clock) begin
        cyc <= cyc + 1;
        prev_grant <= grant;
        if (trans_en && n_st < 64) begin
            st_data[n_st] <= tx_data;
            st_time[n_st] <= cyc;
            n_st <= n_st + 1;
        end
        if (m_ack) n_mack <= n_mack + 1;
        if ((m_ack && prev_grant == 2'b10) || (s_ack && prev_grant == 2'b01))
            lock_viol <= lock_viol + 1;
        if ((m_ack && grant != 2'b01) || (s_ack && grant != 2'b10))
            grant_bad <= grant_bad + 1;
    end

    task automatic run_until_idle(input string tag, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int n = 0; n < max_cyc && !done; n++) begin
            @(negedge clock);
            if ((!m_en || m_idx >= m_len) && (!s_en || s_idx >= s_len) && !active && !tx_busy)
                done = 1'b1;
        end
        check_value({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic enter_reset();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    int base;
    int mbase;
    bit seen;

    initial begin
        reset_n = 1'b0;
        abort   = 1'b0;
        uart_on = 1'b1;
        m_en    = 1'b1;
        s_en    = 1'b1;
        m_len   = 2; m_mem[0] = 8'h11; m_mem[1] = 8'h12;
        s_len   = 2; s_mem[0] = 8'h21; s_mem[1] = 8'h22;

        // Reset with both requests held high.
        repeat (3) @(negedge clock);
        check_value("rst_m_ack",    {31'd0, m_ack},    32'd0);
        check_value("rst_s_ack",    {31'd0, s_ack},    32'd0);
        check_value("rst_trans_en", {31'd0, trans_en}, 32'd0);
        check_value("rst_tx_data",  {24'd0, tx_data},  32'h00);
        check_value("rst_grant",    {30'd0, grant},    32'd0);
        check_value("rst_active",   {31'd0, active},   32'd0);
        check_value("rst_count",    {16'd0, byte_count}, 32'd0);
        base = n_st;
        reset_n = 1'b1;
        @(negedge clock);
        check_value("rel_m_ack",   {31'd0, m_ack},   32'd1);
        check_value("rel_s_ack",   {31'd0, s_ack},   32'd0);
        check_value("rel_grant",   {30'd0, grant},   32'd1);
        check_value("rel_tx_data", {24'd0, tx_data}, 32'h11);
        @(negedge clock);
        check_value("rel_strobe",  {31'd0, trans_en}, 32'd1);
        check_value("rel_ack_off", {31'd0, m_ack},    32'd0);

        // Simultaneous requests: metadata burst first, then sample burst.
        run_until_idle("simul", 300);
        check_value("simul_n",  n_st - base, 32'd4);
        check_value("simul_b0", {24'd0, st_data[base]},   32'h11);
        check_value("simul_b1", {24'd0, st_data[base+1]}, 32'h12);
        check_value("simul_b2", {24'd0, st_data[base+2]}, 32'h21);
        check_value("simul_b3", {24'd0, st_data[base+3]}, 32'h22);
        check_value("simul_lock",  lock_viol, 32'd0);
        check_value("simul_grant", grant_bad, 32'd0);

        // Single metadata burst A1,A2,A3.
        enter_reset();
        s_en  = 1'b0;
        m_len = 3; m_mem[0] = 8'hA1; m_mem[1] = 8'hA2; m_mem[2] = 8'hA3;
        base = n_st;
        reset_n = 1'b1;
        run_until_idle("single", 300);
        check_value("single_n",  n_st - base, 32'd3);
        check_value("single_b0", {24'd0, st_data[base]},   32'hA1);
        check_value("single_b1", {24'd0, st_data[base+1]}, 32'hA2);
        check_value("single_b2", {24'd0, st_data[base+2]}, 32'hA3);
        // 1 cycle to busy + 20 busy cycles + WAIT_DONE/NEXT/SEND.
        check_value("single_gap",   st_time[base+1] - st_time[base], 32'd24);
        check_value("single_count", {16'd0, byte_count}, 32'd3);
        check_value("single_grant", {30'd0, grant},      32'd0);
        check_value("single_active", {31'd0, active},    32'd0);

        // Burst lock: metadata request appears in the middle of a sample burst.
        enter_reset();
        m_en  = 1'b0;
        s_en  = 1'b1;
        m_len = 1; m_mem[0] = 8'h41;
        s_len = 3; s_mem[0] = 8'h31; s_mem[1] = 8'h32; s_mem[2] = 8'h33;
        base = n_st;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clock);
            if (s_idx >= 1) seen = 1'b1;
        end
        check_value("lock_first_ack", {31'd0, seen}, 32'd1);
        m_en = 1'b1;
        run_until_idle("lock", 400);
        check_value("lock_n",  n_st - base, 32'd4);
        check_value("lock_b0", {24'd0, st_data[base]},   32'h31);
        check_value("lock_b2", {24'd0, st_data[base+2]}, 32'h33);
        check_value("lock_b3", {24'd0, st_data[base+3]}, 32'h41);
        check_value("lock_viol",  lock_viol, 32'd0);
        check_value("lock_grant", grant_bad, 32'd0);

        // Busy timeout: UART never reports busy.
        enter_reset();
        uart_on = 1'b0;
        s_en  = 1'b0;
        m_en  = 1'b1;
        m_len = 2; m_mem[0] = 8'h51; m_mem[1] = 8'h52;
        base = n_st;
        reset_n = 1'b1;
        run_until_idle("tmo", 200);
        check_value("tmo_n",     n_st - base, 32'd2);
        check_value("tmo_gap",   st_time[base+1] - st_time[base], 32'd20);
        check_value("tmo_b1",    {24'd0, st_data[base+1]}, 32'h52);
        check_value("tmo_count", {16'd0, byte_count}, 32'd2);

        // Abort during WAIT_DONE while the UART is busy.
        enter_reset();
        uart_on = 1'b1;
        m_len = 3; m_mem[0] = 8'h61; m_mem[1] = 8'h62; m_mem[2] = 8'h63;
        base  = n_st;
        mbase = n_mack;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clock);
            if (n_st > base) seen = 1'b1;
        end
        check_value("abort_strobe_seen", {31'd0, seen}, 32'd1);
        repeat (5) @(negedge clock);
        check_value("abort_busy_pre", {31'd0, tx_busy}, 32'd1);
        abort = 1'b1;
        m_en  = 1'b0;
        @(negedge clock);
        abort = 1'b0;
        check_value("abort_grant",  {30'd0, grant},  32'd0);
        check_value("abort_active", {31'd0, active}, 32'd1);
        check_value("abort_count",  {16'd0, byte_count}, 32'd1);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clock);
            if (!tx_busy) seen = 1'b1;
        end
        check_value("drain_busy_fell", {31'd0, seen}, 32'd1);
        check_value("drain_active_hold", {31'd0, active}, 32'd1);
        @(negedge clock);
        check_value("drain_active_fall", {31'd0, active}, 32'd0);
        repeat (10) @(negedge clock);
        check_value("abort_no_strobe", n_st - base, 32'd1);
        check_value("abort_no_ack",    n_mack - mbase, 32'd1);
        check_value("abort_keep_count", {16'd0, byte_count}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
